mext_sequencer: RTL and testbench

//  Issue controller between the decode/execute stage and the shared multi-cycle multiplier and divider (M extension).

---
 rtl/mext_sequencer_pkg.sv | 48 ++++
 rtl/mext_sequencer_if.sv | 56 +++++
 rtl/mext_sequencer_div_fixup.sv | 37 +++
 rtl/mext_sequencer.sv | 156 +++++++++++++++
 tb/tb_mext_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mext_sequencer_pkg.sv
// Shared definitions for the RV32M issue sequencer.
// Holds the operand width, default timeout, funct3 encodings, special-result
// constants, the FSM state type and small funct3 decode helpers.
package mext_sequencer_pkg;

  localparam int XLEN        = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int TMR_W_DEF   = 7;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Special-result constants for divide-by-zero and signed overflow
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_DIV_WAIT = 3'd3,
    ST_RESP     = 3'd4,
    ST_DRAIN    = 3'd5
  } state_t;

  // DIV/DIVU/REM/REMU all have funct3[2] set
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM/REMU select the remainder rather than the quotient
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // DIV/REM are the signed divider ops (funct3[0] clear)
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/mext_sequencer_if.sv
// Bus bundle between the execute stage, the sequencer and the shared
// multiplier/divider.
//  slave  : sequencer view (takes requests, drives the units and responses)
//  master : environment view (offers requests, models the units, consumes)
interface mext_sequencer_if;
  import mext_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_rs1;
  logic [XLEN-1:0]   req_rs2;
  logic [4:0]        req_rd;
  logic              flush;

  logic              mul_start;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_signed;
  logic              mul_unsigned;
  logic              mul_su;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_p;

  logic              div_start;
  logic [XLEN-1:0]   div_a;
  logic [XLEN-1:0]   div_b;
  logic              div_signed;
  logic              div_done;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
           mul_done, mul_p, div_done, div_quo, div_rem, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, mul_signed, mul_unsigned, mul_su,
           div_start, div_a, div_b, div_signed,
           rsp_valid, rsp_data, rsp_rd, rsp_err, busy
  );

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
           mul_done, mul_p, div_done, div_quo, div_rem, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, mul_signed, mul_unsigned, mul_su,
           div_start, div_a, div_b, div_signed,
           rsp_valid, rsp_data, rsp_rd, rsp_err, busy
  );

endinterface

// File: rtl/mext_sequencer_div_fixup.sv
// mext_div_fixup: combinational detection of the divide cases that never
// reach the divider, with their architectural results.
//  funct3/rs1/rs2 in : offered op and operands
//  special       out : op is resolved here (div-by-zero or signed overflow)
//  quo/rem       out : special quotient/remainder (zero when not special)
module mext_div_fixup
  import mext_sequencer_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic div0_s;
  logic ovf_s;

  // Classify the op and produce the fixed result; div-by-zero takes priority
  always_comb begin
    div0_s  = is_div_op(funct3) && (rs2 == {XLEN{1'b0}});
    ovf_s   = is_signed_div(funct3) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    special = div0_s | ovf_s;
    if (div0_s) begin
      quo = ALL_ONES;
      rem = rs1;
    end else if (ovf_s) begin
      quo = INT_MIN;
      rem = {XLEN{1'b0}};
    end else begin
      quo = {XLEN{1'b0}};
      rem = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/mext_sequencer.sv
// mext_sequencer: issues one RV32M op at a time to the shared multiplier or
// divider, resolves div-by-zero/overflow locally, enforces a start-to-done
// timeout, honours pipeline flush and holds the result until consumed.
//  clk, rst : clock and synchronous active-high reset
//  bus      : request, unit and response signals (mext_sequencer_if.slave)
module mext_sequencer
  import mext_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMR_W   = TMR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mext_sequencer_if.slave bus
);

  state_t          state_r, state_s;
  logic [2:0]      f3_r;
  logic [XLEN-1:0] op_a_r, op_b_r, result_r;
  logic [4:0]      rd_r;
  logic            err_r;
  logic [TMR_W-1:0] timer_r;
  logic            mul_signed_r, mul_unsigned_r, mul_su_r, div_signed_r;

  logic            accept_s, special_s, unit_done_s, timeout_s, waiting_s;
  logic [XLEN-1:0] spec_quo_s, spec_rem_s, captured_s;

  mext_div_fixup u_fixup (
    .funct3  (bus.req_funct3),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .special (special_s),
    .quo     (spec_quo_s),
    .rem     (spec_rem_s)
  );

  // Handshake and timer qualifiers; done is taken only from the unit that owns the op
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && bus.req_valid && !bus.flush;
    unit_done_s = is_div_op(f3_r) ? bus.div_done : bus.mul_done;
    timeout_s   = (timer_r == TMR_W'(TIMEOUT));
    waiting_s   = (state_r == ST_MUL_WAIT) || (state_r == ST_DIV_WAIT);
  end

  // Select the half of the product or the quotient/remainder the op asks for
  always_comb begin
    case (f3_r)
      F3_MUL:                       captured_s = bus.mul_p[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: captured_s = bus.mul_p[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              captured_s = bus.div_quo;
      F3_REM, F3_REMU:              captured_s = bus.div_rem;
      default:                      captured_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; flush wins over done/timeout, and a flush coinciding
  // with done or timeout needs no drain because nothing is owed any more
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = special_s ? ST_RESP : ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (bus.flush)            state_s = ST_IDLE;
        else if (is_div_op(f3_r)) state_s = ST_DIV_WAIT;
        else                      state_s = ST_MUL_WAIT;
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        if (bus.flush)                     state_s = (unit_done_s || timeout_s) ? ST_IDLE : ST_DRAIN;
        else if (unit_done_s || timeout_s) state_s = ST_RESP;
        else                               state_s = state_r;
      end
      ST_RESP: begin
        if (bus.flush || bus.rsp_ready) state_s = ST_IDLE;
        else                            state_s = ST_RESP;
      end
      ST_DRAIN: begin
        if (unit_done_s || timeout_s) state_s = ST_IDLE;
        else                          state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand/mode latch at accept, result capture, and start-to-done timer
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_r           <= 3'b000;
      op_a_r         <= {XLEN{1'b0}};
      op_b_r         <= {XLEN{1'b0}};
      rd_r           <= 5'd0;
      result_r       <= {XLEN{1'b0}};
      err_r          <= 1'b0;
      timer_r        <= {TMR_W{1'b0}};
      mul_signed_r   <= 1'b0;
      mul_unsigned_r <= 1'b0;
      mul_su_r       <= 1'b0;
      div_signed_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        f3_r           <= bus.req_funct3;
        op_a_r         <= bus.req_rs1;
        op_b_r         <= bus.req_rs2;
        rd_r           <= bus.req_rd;
        err_r          <= 1'b0;
        mul_signed_r   <= (bus.req_funct3 == F3_MUL) || (bus.req_funct3 == F3_MULH);
        mul_unsigned_r <= (bus.req_funct3 == F3_MULHU);
        mul_su_r       <= (bus.req_funct3 == F3_MULHSU);
        div_signed_r   <= is_signed_div(bus.req_funct3);
        if (special_s) result_r <= is_rem_op(bus.req_funct3) ? spec_rem_s : spec_quo_s;
        else           result_r <= {XLEN{1'b0}};
      end else if (waiting_s && !bus.flush && unit_done_s) begin
        result_r <= captured_s;
      end else if (waiting_s && !bus.flush && timeout_s) begin
        result_r <= {XLEN{1'b0}};
        err_r    <= 1'b1;
      end

      if (state_r == ST_ISSUE)                       timer_r <= {TMR_W{1'b0}};
      else if (waiting_s || (state_r == ST_DRAIN))   timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Control outputs decoded from the state register; flush gates ready and start
  always_comb begin
    bus.req_ready = (state_r == ST_IDLE) && !bus.flush;
    bus.mul_start = (state_r == ST_ISSUE) && !bus.flush && !is_div_op(f3_r);
    bus.div_start = (state_r == ST_ISSUE) && !bus.flush && is_div_op(f3_r);
    bus.rsp_valid = (state_r == ST_RESP);
    bus.busy      = (state_r != ST_IDLE);
  end

  assign bus.mul_a        = op_a_r;
  assign bus.mul_b        = op_b_r;
  assign bus.div_a        = op_a_r;
  assign bus.div_b        = op_b_r;
  assign bus.mul_signed   = mul_signed_r;
  assign bus.mul_unsigned = mul_unsigned_r;
  assign bus.mul_su       = mul_su_r;
  assign bus.div_signed   = div_signed_r;
  assign bus.rsp_data     = result_r;
  assign bus.rsp_rd       = rd_r;
  assign bus.rsp_err      = err_r;

endmodule

// File: tb/tb_mext_sequencer.sv
// Directed bench for mext_sequencer: a table of ops with hand-computed
// results plus hand-written flush, timeout and reset sequences. The bench
// plays the multiplier/divider itself.
module tb_mext_sequencer;

  localparam int TO = 64;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          unit;   // 0 resolved locally, 1 multiplier, 2 divider
    logic [63:0] p;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [3:0]  modes;  // {mul_signed, mul_unsigned, mul_su, div_signed}
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_mul = 0;
  int   n_div = 0;
  vec_t vecs[15];

  mext_sequencer_if bus ();

  mext_sequencer #(.TIMEOUT(TO), .TMR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mul_start === 1'b1) n_mul <= n_mul + 1;
    if (bus.div_start === 1'b1) n_div <= n_div + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Offer one op in cycle T, return at the negedge of cycle T+1
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic fl);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rd = rd;
    @(negedge clk);
    chk("req_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush = fl;
    @(negedge clk);
  endtask

  task automatic consume();
    @(posedge clk); #1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input int i, input vec_t v);
    int bm, bd;
    bm = n_mul; bd = n_div;
    issue(v.f3, v.a, v.b, v.rd, 1'b0);
    chk($sformatf("v%0d_mul_start", i), {63'd0, bus.mul_start}, {63'd0, v.unit == 1});
    chk($sformatf("v%0d_div_start", i), {63'd0, bus.div_start}, {63'd0, v.unit == 2});
    chk($sformatf("v%0d_modes", i),
        {60'd0, bus.mul_signed, bus.mul_unsigned, bus.mul_su, bus.div_signed}, {60'd0, v.modes});
    chk($sformatf("v%0d_operands", i), {bus.mul_a, bus.div_b}, {v.a, v.b});
    if (v.unit != 0) begin
      // done three cycles after the start pulse
      repeat (2) @(posedge clk);
      @(posedge clk); #1;
      if (v.unit == 1) begin bus.mul_p = v.p; bus.mul_done = 1'b1; end
      else begin bus.div_quo = v.quo; bus.div_rem = v.rem; bus.div_done = 1'b1; end
      @(negedge clk);
      chk($sformatf("v%0d_rsp_early", i), {63'd0, bus.rsp_valid}, 64'd0);
      @(posedge clk); #1;
      bus.mul_done = 1'b0; bus.div_done = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("v%0d_rsp_valid", i), {63'd0, bus.rsp_valid}, 64'd1);
    chk($sformatf("v%0d_rsp", i), {26'd0, bus.rsp_err, bus.rsp_rd, bus.rsp_data}, {26'd0, 1'b0, v.rd, v.exp});
    @(negedge clk);
    chk($sformatf("v%0d_rsp_hold", i), {31'd0, bus.rsp_valid, bus.rsp_data}, {31'd0, 1'b1, v.exp});
    consume();
    @(negedge clk);
    chk($sformatf("v%0d_idle", i), {62'd0, bus.rsp_valid, bus.busy}, 64'd0);
    chk($sformatf("v%0d_start_cnt", i), {32'(n_mul - bm), 32'(n_div - bd)},
        {32'(v.unit == 1), 32'(v.unit == 2)});
  endtask

  initial begin
    int n;
    vecs[0]  = '{MUL,    32'd7,          32'd6,          5'd5,  1, 64'd42,                 32'd0,  32'd0,          4'b1000, 32'd42};
    vecs[1]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  1, 64'hFFFFFFFE_00000001,  32'd0,  32'd0,          4'b0100, 32'hFFFF_FFFE};
    vecs[2]  = '{MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 1, 64'hFFFFFFFE_00000001,  32'd0,  32'd0,          4'b1000, 32'd1};
    vecs[3]  = '{MULH,   32'hFFFF_FFFE,  32'd3,          5'd11, 1, 64'hFFFFFFFF_FFFFFFFA,  32'd0,  32'd0,          4'b1000, 32'hFFFF_FFFF};
    vecs[4]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd12, 1, 64'hFFFFFFFF_FFFFFFFE,  32'd0,  32'd0,          4'b0010, 32'hFFFF_FFFF};
    vecs[5]  = '{DIV,    32'd100,        32'd7,          5'd13, 2, 64'd0,                  32'd14, 32'd2,          4'b0001, 32'd14};
    vecs[6]  = '{REMU,   32'd100,        32'd7,          5'd14, 2, 64'd0,                  32'd14, 32'd2,          4'b0000, 32'd2};
    vecs[7]  = '{DIV,    32'd100,        32'd0,          5'd15, 0, 64'd0,                  32'd0,  32'd0,          4'b0001, 32'hFFFF_FFFF};
    vecs[8]  = '{REMU,   32'd5,          32'd0,          5'd16, 0, 64'd0,                  32'd0,  32'd0,          4'b0000, 32'd5};
    vecs[9]  = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 0, 64'd0,                  32'd0,  32'd0,          4'b0001, 32'h8000_0000};
    vecs[10] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 0, 64'd0,                  32'd0,  32'd0,          4'b0001, 32'd0};
    vecs[11] = '{REMU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 2, 64'd0,                  32'd0,  32'h8000_0000,  4'b0000, 32'h8000_0000};
    vecs[12] = '{DIVU,   32'd7,          32'd0,          5'd20, 0, 64'd0,                  32'd0,  32'd0,          4'b0000, 32'hFFFF_FFFF};
    vecs[13] = '{REM,    32'd7,          32'd0,          5'd21, 0, 64'd0,                  32'd0,  32'd0,          4'b0001, 32'd7};
    vecs[14] = '{DIV,    32'h8000_0000,  32'd1,          5'd22, 2, 64'd0,                  32'h8000_0000, 32'd0,   4'b0001, 32'h8000_0000};

    bus.req_valid = 1'b0; bus.req_funct3 = 3'b000; bus.req_rs1 = 32'd0; bus.req_rs2 = 32'd0;
    bus.req_rd = 5'd0; bus.flush = 1'b0; bus.mul_done = 1'b0; bus.mul_p = 64'd0;
    bus.div_done = 1'b0; bus.div_quo = 32'd0; bus.div_rem = 32'd0; bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_busy", {62'd0, bus.req_ready, bus.busy}, 64'd2);
    chk("rst_starts_valid", {61'd0, bus.mul_start, bus.div_start, bus.rsp_valid}, 64'd0);
    chk("rst_operands", {bus.mul_a | bus.div_a, bus.mul_b | bus.div_b}, 64'd0);
    chk("rst_modes", {60'd0, bus.mul_signed, bus.mul_unsigned, bus.mul_su, bus.div_signed}, 64'd0);
    chk("rst_rsp", {26'd0, bus.rsp_err, bus.rsp_rd, bus.rsp_data}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // Flush while idle: no accept
    @(posedge clk); #1; bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_funct3 = MUL;
    @(negedge clk);
    chk("idle_flush_ready", {63'd0, bus.req_ready}, 64'd0);
    @(posedge clk); #1; bus.flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", {63'd0, bus.busy}, 64'd0);

    // Flush in ISSUE suppresses the start pulse
    n = n_mul;
    issue(MUL, 32'd3, 32'd4, 5'd1, 1'b1);
    chk("issue_flush_start", {63'd0, bus.mul_start}, 64'd0);
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    chk("issue_flush_idle", {62'd0, bus.busy, bus.req_ready}, 64'd1);
    chk("issue_flush_cnt", 64'(n_mul - n), 64'd0);

    // Flush two cycles into DIV_WAIT, then the owed done drains it
    issue(DIVU, 32'd100, 32'd7, 5'd2, 1'b0);
    chk("drain_div_start", {63'd0, bus.div_start}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    chk("drain_state", {61'd0, bus.busy, bus.req_ready, bus.rsp_valid}, 64'd4);
    @(posedge clk); #1; bus.div_quo = 32'd14; bus.div_rem = 32'd2; bus.div_done = 1'b1;
    @(negedge clk);
    chk("drain_done_cycle", {62'd0, bus.busy, bus.rsp_valid}, 64'd2);
    @(posedge clk); #1; bus.div_done = 1'b0;
    @(negedge clk);
    chk("drain_exit", {61'd0, bus.busy, bus.req_ready, bus.rsp_valid}, 64'd2);
    run_op(100, vecs[0]);

    // Flush in RESP drops the result
    issue(DIV, 32'd9, 32'd0, 5'd3, 1'b0);
    chk("resp_flush_valid", {63'd0, bus.rsp_valid}, 64'd1);
    @(posedge clk); #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    chk("resp_flush_idle", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);

    // Multiplier never answers: timeout response with err
    issue(MUL, 32'd7, 32'd6, 5'd4, 1'b0);
    chk("to_start", {63'd0, bus.mul_start}, 64'd1);
    n = 0;
    while (!bus.rsp_valid && n < TO + 10) begin @(negedge clk); n++; end
    chk("to_latency", {63'd0, (n >= TO) && (n <= TO + 2)}, 64'd1);
    chk("to_rsp", {25'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rd, bus.rsp_data}, {25'd0, 1'b1, 1'b1, 5'd4, 32'd0});
    consume();
    bus.mul_p = 64'd42; bus.mul_done = 1'b1;
    @(negedge clk);
    chk("late_done", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
    @(posedge clk); #1; bus.mul_done = 1'b0;

    // Reset in MUL_WAIT
    issue(MULHU, 32'd5, 32'd6, 5'd7, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {60'd0, bus.req_ready, bus.busy, bus.rsp_valid, bus.mul_start}, 64'd8);
    chk("rst_mid_data", {bus.mul_a, bus.mul_b}, 64'd0);
    chk("rst_mid_modes", {57'd0, bus.mul_signed, bus.mul_unsigned, bus.rsp_rd}, 64'd0);
    @(posedge clk); #1; bus.mul_done = 1'b1;
    @(negedge clk);
    chk("rst_late_done", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
    @(posedge clk); #1; bus.mul_done = 1'b0;
    run_op(101, vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
